// File: rtl/dcache_direct_mapped_if.sv
// CPU-side and memory-side signal bundle for dcache_direct_mapped.
// The slave modport is the cache itself. The master modport is whatever drives
// the CPU requests and answers the memory requests.
interface dcache_direct_mapped_if #(
   parameter int DATA_W          = 8,
   parameter int ADDR_W          = 8,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int CNT_W           = 16
);
   localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int BLK_W = DATA_W * WORDS_PER_BLOCK;

   // CPU load/store path
   logic                    READ;
   logic                    WRITE;
   logic [ADDR_W-1:0]       ADDRESS;
   logic [DATA_W-1:0]       WRITEDATA;
   logic [DATA_W-1:0]       READDATA;
   logic                    BUSYWAIT;

   // Block-wide memory path
   logic                    MEM_READ;
   logic                    MEM_WRITE;
   logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS;
   logic [BLK_W-1:0]        MEM_WRITEDATA;
   logic [BLK_W-1:0]        MEM_READDATA;
   logic                    MEM_BUSYWAIT;

   // Performance counters
   logic [CNT_W-1:0]        HIT_COUNT;
   logic [CNT_W-1:0]        MISS_COUNT;

   modport master (
      output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
             HIT_COUNT, MISS_COUNT
   );

   modport slave (
      input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
             HIT_COUNT, MISS_COUNT
   );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache.
// Hits are served combinationally in IDLE with zero latency. A miss optionally
// writes the dirty victim back, fetches the new block, and installs it in UPDATE.
// Saturating hit/miss counters are provided for performance runs.
module dcache_direct_mapped #(
   parameter int DATA_W          = 8,
   parameter int ADDR_W          = 8,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int NUM_SETS        = 8,
   parameter int CNT_W           = 16
) (
   input logic                   CLK,
   input logic                   RESET,
   dcache_direct_mapped_if.slave bus
);
   localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
   localparam int IDX_W   = $clog2(NUM_SETS);
   localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
   localparam int BLK_W   = DATA_W * WORDS_PER_BLOCK;
   localparam int MADDR_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_e;

   state_e               state, state_nxt;

   logic [BLK_W-1:0]     data_arr [NUM_SETS];
   logic [TAG_W-1:0]     tag_arr  [NUM_SETS];
   logic [NUM_SETS-1:0]  valid_bits;
   logic [NUM_SETS-1:0]  dirty_bits;

   logic [TAG_W-1:0]     addr_tag;
   logic [IDX_W-1:0]     addr_idx;
   logic [OFF_W-1:0]     addr_off;

   // Line being filled; captured when the miss is detected so the fill still
   // completes correctly if the CPU drops its request mid-miss.
   logic [TAG_W-1:0]     miss_tag;
   logic [IDX_W-1:0]     miss_idx;
   logic [BLK_W-1:0]     fill_buf;

   logic [CNT_W-1:0]     hit_cnt;
   logic [CNT_W-1:0]     miss_cnt;

   logic                 req;
   logic                 hit;
   logic                 idle_hit;
   logic                 idle_miss;
   logic [DATA_W-1:0]    rd_word;

   logic                 mem_read;
   logic                 mem_write;
   logic [MADDR_W-1:0]   mem_addr;
   logic [BLK_W-1:0]     mem_wdata;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign {addr_tag, addr_idx, addr_off} = bus.ADDRESS;

   assign req       = bus.READ | bus.WRITE;
   assign hit       = valid_bits[addr_idx] && (tag_arr[addr_idx] == addr_tag);
   assign idle_hit  = (state == IDLE) && hit;
   assign idle_miss = (state == IDLE) && req && !hit;
   assign rd_word   = data_arr[addr_idx][int'(addr_off)*DATA_W +: DATA_W];

   // CPU-facing outputs are combinational. BUSYWAIT is also forced low while
   // reset is asserted, so the CPU sees no stall during reset.
   assign bus.READDATA   = (bus.READ && idle_hit) ? rd_word : '0;
   assign bus.BUSYWAIT   = RESET && req && !idle_hit;
   assign bus.MEM_READ      = mem_read;
   assign bus.MEM_WRITE     = mem_write;
   assign bus.MEM_ADDRESS   = mem_addr;
   assign bus.MEM_WRITEDATA = mem_wdata;
   assign bus.HIT_COUNT     = hit_cnt;
   assign bus.MISS_COUNT    = miss_cnt;

   // State register, line status bits, miss bookkeeping and counters.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         valid_bits <= '0;
         dirty_bits <= '0;
         miss_tag   <= '0;
         miss_idx   <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (req && idle_hit) begin
            hit_cnt <= sat_inc(hit_cnt);
            if (bus.WRITE) dirty_bits[addr_idx] <= 1'b1;
         end
         if (idle_miss) begin
            miss_cnt <= sat_inc(miss_cnt);
            miss_tag <= addr_tag;
            miss_idx <= addr_idx;
         end
         if (state == UPDATE) begin
            valid_bits[miss_idx] <= 1'b1;
            dirty_bits[miss_idx] <= 1'b0;
         end
      end
   end

   // Data and tag storage: block fill on UPDATE, single-word store on a write hit.
   always_ff @(posedge CLK) begin
      if (state == FETCH && !bus.MEM_BUSYWAIT) fill_buf <= bus.MEM_READDATA;
      if (state == UPDATE) begin
         data_arr[miss_idx] <= fill_buf;
         tag_arr[miss_idx]  <= miss_tag;
      end else if (bus.WRITE && idle_hit) begin
         data_arr[addr_idx][int'(addr_off)*DATA_W +: DATA_W] <= bus.WRITEDATA;
      end
   end

   // Next-state logic and the memory-side request outputs.
   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (idle_miss)
               state_nxt = (valid_bits[addr_idx] && dirty_bits[addr_idx]) ? WRITEBACK : FETCH;
         end
         WRITEBACK: begin
            mem_write = 1'b1;
            mem_addr  = {tag_arr[miss_idx], miss_idx};
            mem_wdata = data_arr[miss_idx];
            if (!bus.MEM_BUSYWAIT) state_nxt = FETCH;
         end
         FETCH: begin
            mem_read = 1'b1;
            mem_addr = {miss_tag, miss_idx};
            if (!bus.MEM_BUSYWAIT) state_nxt = UPDATE;
         end
         UPDATE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Testbench for dcache_direct_mapped: behavioural block memory with a
// programmable wait count, read-data and memory-event scoreboards, and a
// second instance with narrow counters for saturation.
module tb_dcache_direct_mapped;
   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   dcache_direct_mapped_if #(.DATA_W(8), .ADDR_W(8), .WORDS_PER_BLOCK(4), .CNT_W(16)) bus ();
   dcache_direct_mapped_if #(.DATA_W(8), .ADDR_W(8), .WORDS_PER_BLOCK(4), .CNT_W(4))  bus4 ();

   dcache_direct_mapped #(.DATA_W(8), .ADDR_W(8), .WORDS_PER_BLOCK(4), .NUM_SETS(8), .CNT_W(16))
      dut (.CLK(CLK), .RESET(RESET), .bus(bus));
   dcache_direct_mapped #(.DATA_W(8), .ADDR_W(8), .WORDS_PER_BLOCK(4), .NUM_SETS(8), .CNT_W(4))
      dut4 (.CLK(CLK), .RESET(RESET), .bus(bus4));

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_hit  = 0;
   int exp_miss = 0;

   // Memory model: completes a request after mem_wait busy cycles.
   logic [31:0] mem [64];
   logic        mem_loaded = 1'b0;
   int          mem_wait   = 0;
   int          mem_cnt    = 0;
   logic        mem_req;

   function automatic logic [31:0] init_val(input int a);
      case (a)
         1:       return 32'h44332211;
         4:       return 32'h0D0C0B0A;
         9:       return 32'h88776655;
         12:      return 32'hDDCCBBAA;
         default: return {4{8'(a)}};
      endcase
   endfunction

   assign mem_req          = bus.MEM_READ | bus.MEM_WRITE;
   assign bus.MEM_BUSYWAIT = !(mem_req && mem_cnt == mem_wait);
   assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
   assign bus4.MEM_BUSYWAIT = 1'b0;
   assign bus4.MEM_READDATA = 32'h04030201;

   always @(posedge CLK) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
         mem_loaded <= 1'b1;
      end else if (mem_req && mem_cnt == mem_wait) begin
         if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
         mem_cnt <= 0;
      end else if (mem_req) begin
         mem_cnt <= mem_cnt + 1;
      end else begin
         mem_cnt <= 0;
      end
   end

   // Observed memory transactions (one entry per completed request).
   typedef struct packed {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] blk;
   } mem_ev_t;
   mem_ev_t       obs_q[$];
   mem_ev_t       exp_mq[$];
   logic [7:0]    rd_q[$];
   int            mem_rd_cyc = 0;
   int            both_cnt   = 0;

   always @(negedge CLK) begin
      if (bus.MEM_READ) mem_rd_cyc <= mem_rd_cyc + 1;
      if (bus.MEM_READ && bus.MEM_WRITE) both_cnt <= both_cnt + 1;
      if (mem_req && !bus.MEM_BUSYWAIT)
         obs_q.push_back('{wr: bus.MEM_WRITE, addr: bus.MEM_ADDRESS,
                           blk: bus.MEM_WRITE ? bus.MEM_WRITEDATA : bus.MEM_READDATA});
   end

   // Drives one CPU access and holds it until BUSYWAIT drops (bounded).
   task automatic cpu_access(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                             output logic [7:0] rd, output int busy, output bit tmo);
      @(negedge CLK);
      bus.READ = !wr; bus.WRITE = wr; bus.ADDRESS = addr; bus.WRITEDATA = wd;
      busy = 0; tmo = 1'b0;
      #1;
      while (bus.BUSYWAIT !== 1'b0) begin
         busy++;
         if (busy > 200) begin tmo = 1'b1; break; end
         @(negedge CLK); #1;
      end
      rd = bus.READDATA;
      @(negedge CLK);
      bus.READ = 1'b0; bus.WRITE = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      bus.READ = 1'b1; bus.WRITE = 1'b0; bus.ADDRESS = 8'h05; bus.WRITEDATA = '0;
      bus4.READ = 1'b0; bus4.WRITE = 1'b0; bus4.ADDRESS = '0; bus4.WRITEDATA = '0;
      repeat (3) @(negedge CLK);
      #1;
      n_cmp++; if (bus.BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busywait: got %b expected 0", bus.BUSYWAIT); end
      n_cmp++; if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got rd=%b wr=%b expected 0 0", bus.MEM_READ, bus.MEM_WRITE); end
      n_cmp++; if (bus.MEM_ADDRESS !== 6'h0 || bus.MEM_WRITEDATA !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr=%h data=%h expected 0", bus.MEM_ADDRESS, bus.MEM_WRITEDATA); end
      n_cmp++; if (bus.READDATA !== 8'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", bus.READDATA); end
      n_cmp++; if (bus.HIT_COUNT !== 16'h0 || bus.MISS_COUNT !== 16'h0) begin n_fail++; $display("FAIL reset_counters: got hit=%0d miss=%0d expected 0 0", bus.HIT_COUNT, bus.MISS_COUNT); end
      bus.READ = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_read_miss();
      logic [7:0] rd, e; int busy; bit tmo; mem_ev_t o, x;
      rd_q.push_back(8'h22);
      exp_mq.push_back('{wr: 1'b0, addr: 6'h01, blk: 32'h44332211});
      cpu_access(1'b0, 8'h05, 8'h00, rd, busy, tmo);
      exp_hit++; exp_miss++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || rd !== e) begin n_fail++; $display("FAIL miss_readdata: got %h expected %h", rd, e); end
      n_cmp++; if (busy !== 3) begin n_fail++; $display("FAIL miss_latency: got %0d expected 3", busy); end
      n_cmp++; if (obs_q.size() !== exp_mq.size()) begin n_fail++; $display("FAIL miss_mem_events: got %0d expected %0d", obs_q.size(), exp_mq.size()); end
      while (obs_q.size() > 0 && exp_mq.size() > 0) begin
         o = obs_q.pop_front(); x = exp_mq.pop_front();
         n_cmp++; if (o !== x) begin n_fail++; $display("FAIL miss_mem_txn: got wr=%b addr=%h blk=%h expected wr=%b addr=%h blk=%h", o.wr, o.addr, o.blk, x.wr, x.addr, x.blk); end
      end
      obs_q.delete(); exp_mq.delete();
      n_cmp++; if (bus.HIT_COUNT !== 16'(exp_hit) || bus.MISS_COUNT !== 16'(exp_miss)) begin n_fail++; $display("FAIL miss_counters: got hit=%0d miss=%0d expected %0d %0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hit, exp_miss); end
   endtask

   task automatic test_read_hit();
      logic [7:0] rd, e; int busy; bit tmo;
      rd_q.push_back(8'h33);
      cpu_access(1'b0, 8'h06, 8'h00, rd, busy, tmo);
      exp_hit++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || rd !== e) begin n_fail++; $display("FAIL hit_readdata: got %h expected %h", rd, e); end
      n_cmp++; if (busy !== 0) begin n_fail++; $display("FAIL hit_busywait: got %0d busy cycles expected 0", busy); end
      n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL hit_mem_events: got %0d expected 0", obs_q.size()); end
      obs_q.delete();
      n_cmp++; if (bus.HIT_COUNT !== 16'(exp_hit) || bus.MISS_COUNT !== 16'(exp_miss)) begin n_fail++; $display("FAIL hit_counters: got hit=%0d miss=%0d expected %0d %0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hit, exp_miss); end
   endtask

   task automatic test_writeback();
      logic [7:0] rd, e; int busy; bit tmo; mem_ev_t o, x;
      cpu_access(1'b1, 8'h04, 8'hAA, rd, busy, tmo);
      exp_hit++;
      n_cmp++; if (tmo || busy !== 0) begin n_fail++; $display("FAIL write_hit_busy: got %0d expected 0", busy); end
      rd_q.push_back(8'h55);
      exp_mq.push_back('{wr: 1'b1, addr: 6'h01, blk: 32'h443322AA});
      exp_mq.push_back('{wr: 1'b0, addr: 6'h09, blk: 32'h88776655});
      cpu_access(1'b0, 8'h24, 8'h00, rd, busy, tmo);
      exp_hit++; exp_miss++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || rd !== e) begin n_fail++; $display("FAIL wb_readdata: got %h expected %h", rd, e); end
      n_cmp++; if (busy !== 4) begin n_fail++; $display("FAIL wb_latency: got %0d expected 4", busy); end
      n_cmp++; if (obs_q.size() !== exp_mq.size()) begin n_fail++; $display("FAIL wb_mem_events: got %0d expected %0d", obs_q.size(), exp_mq.size()); end
      while (obs_q.size() > 0 && exp_mq.size() > 0) begin
         o = obs_q.pop_front(); x = exp_mq.pop_front();
         n_cmp++; if (o !== x) begin n_fail++; $display("FAIL wb_mem_txn: got wr=%b addr=%h blk=%h expected wr=%b addr=%h blk=%h", o.wr, o.addr, o.blk, x.wr, x.addr, x.blk); end
      end
      obs_q.delete(); exp_mq.delete();
      n_cmp++; if (bus.HIT_COUNT !== 16'(exp_hit) || bus.MISS_COUNT !== 16'(exp_miss)) begin n_fail++; $display("FAIL wb_counters: got hit=%0d miss=%0d expected %0d %0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hit, exp_miss); end
   endtask

   task automatic test_fetch_wait();
      logic [7:0] rd, e; int busy, rd0; bit tmo; mem_ev_t o;
      mem_wait = 5;
      rd0 = mem_rd_cyc;
      rd_q.push_back(8'h22);
      cpu_access(1'b0, 8'h05, 8'h00, rd, busy, tmo);
      exp_hit++; exp_miss++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || rd !== e) begin n_fail++; $display("FAIL wait_readdata: got %h expected %h", rd, e); end
      n_cmp++; if (busy !== 8) begin n_fail++; $display("FAIL wait_busy_cycles: got %0d expected 8", busy); end
      n_cmp++; if (mem_rd_cyc - rd0 !== 6) begin n_fail++; $display("FAIL wait_mem_read_cycles: got %0d expected 6", mem_rd_cyc - rd0); end
      n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL wait_mem_events: got %0d expected 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; if (o.wr !== 1'b0 || o.addr !== 6'h01) begin n_fail++; $display("FAIL wait_mem_txn: got wr=%b addr=%h expected wr=0 addr=01", o.wr, o.addr); end
      end
      obs_q.delete();
      n_cmp++; if (bus.HIT_COUNT !== 16'(exp_hit) || bus.MISS_COUNT !== 16'(exp_miss)) begin n_fail++; $display("FAIL wait_counters: got hit=%0d miss=%0d expected %0d %0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hit, exp_miss); end
   endtask

   task automatic test_reset_mid_fetch();
      logic [7:0] rd, e; int busy, guard; bit tmo; mem_ev_t o;
      mem_wait = 5;
      @(negedge CLK);
      bus.READ = 1'b1; bus.ADDRESS = 8'h24;
      guard = 0;
      #1;
      while (bus.MEM_READ !== 1'b1 && guard < 50) begin @(negedge CLK); #1; guard++; end
      n_cmp++; if (bus.MEM_READ !== 1'b1) begin n_fail++; $display("FAIL midrst_fetch_start: got %b expected 1", bus.MEM_READ); end
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      n_cmp++; if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL midrst_async_drop: got mem_read=%b busywait=%b expected 0 0", bus.MEM_READ, bus.BUSYWAIT); end
      n_cmp++; if (bus.MISS_COUNT !== 16'h0 || bus.HIT_COUNT !== 16'h0) begin n_fail++; $display("FAIL midrst_counters: got hit=%0d miss=%0d expected 0 0", bus.HIT_COUNT, bus.MISS_COUNT); end
      bus.READ = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      mem_wait = 0;
      exp_hit = 0; exp_miss = 0;
      n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL midrst_mem_events: got %0d expected 0", obs_q.size()); end
      obs_q.delete();
      rd_q.push_back(8'h22);
      cpu_access(1'b0, 8'h05, 8'h00, rd, busy, tmo);
      exp_hit++; exp_miss++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || rd !== e) begin n_fail++; $display("FAIL midrst_readdata: got %h expected %h", rd, e); end
      n_cmp++; if (busy !== 3) begin n_fail++; $display("FAIL midrst_remiss: got %0d busy cycles expected 3", busy); end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; if (o.wr !== 1'b0 || o.addr !== 6'h01) begin n_fail++; $display("FAIL midrst_mem_txn: got wr=%b addr=%h expected wr=0 addr=01", o.wr, o.addr); end
      end
      obs_q.delete();
      n_cmp++; if (bus.HIT_COUNT !== 16'(exp_hit) || bus.MISS_COUNT !== 16'(exp_miss)) begin n_fail++; $display("FAIL midrst_after_counters: got hit=%0d miss=%0d expected %0d %0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hit, exp_miss); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      logic [7:0] words [4] = '{8'hAA, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) rd_q.push_back(words[i]);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         bus.READ = 1'b1; bus.ADDRESS = 8'h04 + 8'(i);
         #1;
         e = rd_q.pop_front();
         n_cmp++; if (bus.BUSYWAIT !== 1'b0 || bus.READDATA !== e) begin n_fail++; $display("FAIL b2b_word%0d: got busy=%b data=%h expected busy=0 data=%h", i, bus.BUSYWAIT, bus.READDATA, e); end
         exp_hit++;
      end
      @(negedge CLK);
      bus.READ = 1'b0;
      #1;
      n_cmp++; if (bus.HIT_COUNT !== 16'(exp_hit) || bus.MISS_COUNT !== 16'(exp_miss)) begin n_fail++; $display("FAIL b2b_counters: got hit=%0d miss=%0d expected %0d %0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hit, exp_miss); end
   endtask

   task automatic test_write_miss();
      logic [7:0] rd, e; int busy; bit tmo; mem_ev_t o, x;
      exp_mq.push_back('{wr: 1'b0, addr: 6'h04, blk: 32'h0D0C0B0A});
      cpu_access(1'b1, 8'h13, 8'h5A, rd, busy, tmo);
      exp_hit++; exp_miss++;
      n_cmp++; if (tmo || busy !== 3) begin n_fail++; $display("FAIL wmiss_latency: got %0d expected 3", busy); end
      rd_q.push_back(8'h5A);
      cpu_access(1'b0, 8'h13, 8'h00, rd, busy, tmo);
      exp_hit++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || busy !== 0 || rd !== e) begin n_fail++; $display("FAIL wmiss_stored_word: got %h busy=%0d expected %h busy=0", rd, busy, e); end
      rd_q.push_back(8'h0A);
      cpu_access(1'b0, 8'h10, 8'h00, rd, busy, tmo);
      exp_hit++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || rd !== e) begin n_fail++; $display("FAIL wmiss_fill_word: got %h expected %h", rd, e); end
      exp_mq.push_back('{wr: 1'b1, addr: 6'h04, blk: 32'h5A0C0B0A});
      exp_mq.push_back('{wr: 1'b0, addr: 6'h0C, blk: 32'hDDCCBBAA});
      rd_q.push_back(8'hDD);
      cpu_access(1'b0, 8'h33, 8'h00, rd, busy, tmo);
      exp_hit++; exp_miss++;
      e = rd_q.pop_front();
      n_cmp++; if (tmo || rd !== e || busy !== 4) begin n_fail++; $display("FAIL evict_read: got %h busy=%0d expected %h busy=4", rd, busy, e); end
      n_cmp++; if (obs_q.size() !== exp_mq.size()) begin n_fail++; $display("FAIL evict_mem_events: got %0d expected %0d", obs_q.size(), exp_mq.size()); end
      while (obs_q.size() > 0 && exp_mq.size() > 0) begin
         o = obs_q.pop_front(); x = exp_mq.pop_front();
         n_cmp++; if (o !== x) begin n_fail++; $display("FAIL evict_mem_txn: got wr=%b addr=%h blk=%h expected wr=%b addr=%h blk=%h", o.wr, o.addr, o.blk, x.wr, x.addr, x.blk); end
      end
      obs_q.delete(); exp_mq.delete();
      n_cmp++; if (bus.HIT_COUNT !== 16'(exp_hit) || bus.MISS_COUNT !== 16'(exp_miss)) begin n_fail++; $display("FAIL wmiss_counters: got hit=%0d miss=%0d expected %0d %0d", bus.HIT_COUNT, bus.MISS_COUNT, exp_hit, exp_miss); end
      n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL mem_rd_wr_exclusive: got %0d overlap cycles expected 0", both_cnt); end
   endtask

   task automatic test_saturate();
      int guard;
      @(negedge CLK);
      bus4.READ = 1'b1; bus4.ADDRESS = 8'h00;
      guard = 0;
      #1;
      while (bus4.BUSYWAIT !== 1'b0 && guard < 50) begin @(negedge CLK); #1; guard++; end
      n_cmp++; if (bus4.BUSYWAIT !== 1'b0 || bus4.READDATA !== 8'h01) begin n_fail++; $display("FAIL sat_fill: got busy=%b data=%h expected busy=0 data=01", bus4.BUSYWAIT, bus4.READDATA); end
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            n_cmp++; if (bus4.HIT_COUNT !== 4'd10) begin n_fail++; $display("FAIL sat_midway: got %0d expected 10", bus4.HIT_COUNT); end
         end
         @(negedge CLK); #1;
      end
      bus4.READ = 1'b0;
      n_cmp++; if (bus4.HIT_COUNT !== 4'd15) begin n_fail++; $display("FAIL sat_hit_count: got %0d expected 15", bus4.HIT_COUNT); end
      n_cmp++; if (bus4.MISS_COUNT !== 4'd1) begin n_fail++; $display("FAIL sat_miss_count: got %0d expected 1", bus4.MISS_COUNT); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_writeback();
      test_fetch_wait();
      test_reset_mid_fetch();
      test_back_to_back();
      test_write_miss();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
endmodule
